// File: rtl/mac_mgnt_arb.sv
// Round-robin arbiter sharing one mac_ctrl management port among N_REQ requesters.
// Latency: sys_req 1 cycle after grant; write completes at +2, read 1 cycle after response or on timeout.
module mac_mgnt_arb #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn_sys,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_wr,
    input  logic [8*N_REQ-1:0]   req_addr,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [7:0]           resp_data,
    output logic                 resp_err,
    output logic                 sys_req_valid,
    output logic                 sys_req_wr,
    output logic [7:0]           sys_req_addr,
    input  logic                 sys_resp_valid,
    input  logic [7:0]           sys_resp_data,
    output logic                 busy,
    output logic                 stray_resp
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = 16;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [7:0]        resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              sys_req_valid_q, sys_req_valid_d;
    logic              sys_req_wr_q, sys_req_wr_d;
    logic [7:0]        sys_req_addr_q, sys_req_addr_d;
    logic              busy_q, busy_d;
    logic              stray_resp_q, stray_resp_d;

    logic              found;
    logic [IW-1:0]     scan_idx;
    logic [IW-1:0]     pick_idx;
    int                pos;

    // Scan positions are reduced modulo N_REQ so no index beyond the last requester is ever read.
    always_comb begin
        found    = 1'b0;
        pick_idx = rr_ptr_q;
        scan_idx = '0;
        pos      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            scan_idx = IW'(pos);
            if (!found && req_valid[scan_idx]) begin
                found    = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        cnt_d           = cnt_q;
        resp_valid_d    = '0;
        resp_data_d     = resp_data_q;
        resp_err_d      = 1'b0;
        sys_req_valid_d = 1'b0;
        sys_req_wr_d    = sys_req_wr_q;
        sys_req_addr_d  = sys_req_addr_q;
        stray_resp_d    = stray_resp_q | (sys_resp_valid && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d         = pick_idx;
                    sys_req_valid_d = 1'b1;
                    sys_req_wr_d    = req_wr[pick_idx];
                    sys_req_addr_d  = req_addr[{pick_idx, 3'b000} +: 8];
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sys_req_wr_q) begin
                    resp_valid_d[grant_q] = 1'b1;
                    state_d               = ST_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the timeout cycle takes precedence over the timeout.
                if (sys_resp_valid) begin
                    resp_valid_d[grant_q] = 1'b1;
                    resp_data_d           = sys_resp_data;
                    state_d               = ST_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    resp_valid_d[grant_q] = 1'b1;
                    resp_data_d           = 8'hFF;
                    resp_err_d            = 1'b1;
                    state_d               = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            grant_q         <= '0;
            cnt_q           <= '0;
            resp_valid_q    <= '0;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b0;
            sys_req_valid_q <= 1'b0;
            sys_req_wr_q    <= 1'b0;
            sys_req_addr_q  <= '0;
            busy_q          <= 1'b0;
            stray_resp_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            cnt_q           <= cnt_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_err_q      <= resp_err_d;
            sys_req_valid_q <= sys_req_valid_d;
            sys_req_wr_q    <= sys_req_wr_d;
            sys_req_addr_q  <= sys_req_addr_d;
            busy_q          <= busy_d;
            stray_resp_q    <= stray_resp_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;
    assign sys_req_valid = sys_req_valid_q;
    assign sys_req_wr    = sys_req_wr_q;
    assign sys_req_addr  = sys_req_addr_q;
    assign busy          = busy_q;
    assign stray_resp    = stray_resp_q;

endmodule

// File: tb/tb_mac_mgnt_arb.sv
// Bench for mac_mgnt_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mac_mgnt_arb;
    localparam int N  = 3;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rstn_sys;
    logic [N-1:0]     req_valid, req_wr;
    logic [8*N-1:0]   req_addr;
    logic [N-1:0]     resp_valid;
    logic [7:0]       resp_data;
    logic             resp_err;
    logic             sys_req_valid, sys_req_wr;
    logic [7:0]       sys_req_addr;
    logic             sys_resp_valid;
    logic [7:0]       sys_resp_data;
    logic             busy, stray_resp;

    mac_mgnt_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rstn_sys       (rstn_sys),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .sys_req_valid  (sys_req_valid),
        .sys_req_wr     (sys_req_wr),
        .sys_req_addr   (sys_req_addr),
        .sys_resp_valid (sys_resp_valid),
        .sys_resp_data  (sys_resp_data),
        .busy           (busy),
        .stray_resp     (stray_resp)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc   = 0;
    int         rr_m  = 0;
    logic       exp_stray = 1'b0;
    logic [7:0] last_data = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr_m + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_resp_vld"}, 32'(resp_valid), 32'(0));
        check_eq({tag, "_sys_vld"},  32'(sys_req_valid), 32'(0));
        check_eq({tag, "_busy"},     32'(busy), 32'(0));
        check_eq({tag, "_err"},      32'(resp_err), 32'(0));
        check_eq({tag, "_data"},     32'(resp_data), 32'(last_data));
        check_eq({tag, "_stray"},    32'(stray_resp), 32'(exp_stray));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_resp_vld"}, 32'(resp_valid), 32'(0));
        check_eq({tag, "_data"},     32'(resp_data), 32'(0));
        check_eq({tag, "_err"},      32'(resp_err), 32'(0));
        check_eq({tag, "_sys_vld"},  32'(sys_req_valid), 32'(0));
        check_eq({tag, "_sys_wr"},   32'(sys_req_wr), 32'(0));
        check_eq({tag, "_sys_addr"}, 32'(sys_req_addr), 32'(0));
        check_eq({tag, "_busy"},     32'(busy), 32'(0));
        check_eq({tag, "_stray"},    32'(stray_resp), 32'(0));
    endtask

    task automatic model_reset();
        rr_m      = 0;
        exp_stray = 1'b0;
        last_data = 8'h00;
    endtask

    task automatic do_reset();
        rstn_sys       = 1'b0;
        req_valid      = '0;
        req_wr         = '0;
        req_addr       = '0;
        sys_resp_valid = 1'b0;
        sys_resp_data  = 8'h00;
        tick();
        tick();
        rstn_sys = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] a);
        req_valid[i]       = 1'b1;
        req_wr[i]          = wr;
        req_addr[8*i +: 8] = a;
    endtask

    // One transaction from an IDLE cycle; d = WAIT cycles before the response (d >= TO: never).
    task automatic run_txn(input int d, input bit drop, input bit mutate, input bit keep);
        int            g, t0, exp_sys, exp_resp, r_cyc;
        logic          w;
        logic [7:0]    a, rd;
        logic [N-1:0]  oh;
        g = pick();
        if (g < 0) g = 0;
        w  = req_wr[g];
        a  = req_addr[8*g +: 8];
        rd = 8'($urandom);
        t0 = cyc;
        exp_sys = t0 + 1;
        r_cyc   = -1;
        if (w) exp_resp = t0 + 2;
        else if (d < TO) begin
            r_cyc    = t0 + 2 + d;
            exp_resp = r_cyc + 1;
        end else exp_resp = t0 + 2 + TO;
        oh    = '0;
        oh[g] = 1'b1;
        while (cyc < exp_resp) begin
            sys_resp_valid = (cyc == r_cyc);
            sys_resp_data  = (cyc == r_cyc) ? rd : 8'($urandom);
            tick();
            if (cyc == exp_sys) begin
                check_eq("sys_wr",   32'(sys_req_wr), 32'(w));
                check_eq("sys_addr", 32'(sys_req_addr), 32'(a));
                if (drop) req_valid[g] = 1'b0;
                if (mutate) begin
                    req_wr[g]          = ~req_wr[g];
                    req_addr[8*g +: 8] = ~a;
                end
            end
            if (cyc == exp_resp && !w) last_data = (d < TO) ? rd : 8'hFF;
            check_eq("sys_vld",  32'(sys_req_valid), 32'(cyc == exp_sys));
            check_eq("resp_vld", 32'(resp_valid), 32'((cyc == exp_resp) ? oh : '0));
            check_eq("err",      32'(resp_err), 32'(cyc == exp_resp && !w && d >= TO));
            check_eq("data",     32'(resp_data), 32'(last_data));
            check_eq("busy",     32'(busy), 32'(1));
            check_eq("stray",    32'(stray_resp), 32'(exp_stray));
        end
        sys_resp_valid = 1'b0;
        rr_m = (g + 1) % N;
        if (!keep) req_valid[g] = 1'b0;
        tick();
        check_eq("idle_resp_vld", 32'(resp_valid), 32'(0));
        check_eq("idle_sys_vld",  32'(sys_req_valid), 32'(0));
        check_eq("idle_busy",     32'(busy), 32'(0));
        check_eq("idle_err",      32'(resp_err), 32'(0));
    endtask

    task automatic drain();
        for (int n = 0; n < 2 * N && pick() >= 0; n++) run_txn(1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        do_reset();
        check_all_zero("reset");

        // Single read, requester 0, response 3 cycles after sys_req_valid.
        set_req(0, 1'b0, 8'h10);
        run_txn(2, 1'b0, 1'b0, 1'b0);
        check_eq("rd0_data", 32'(resp_data), 32'(last_data));

        // Write, requester 1.
        set_req(1, 1'b1, 8'h12);
        run_txn(0, 1'b0, 1'b0, 1'b0);

        // Two requesters holding reads continuously from reset.
        do_reset();
        set_req(0, 1'b0, 8'h30);
        set_req(1, 1'b0, 8'h31);
        for (int n = 0; n < 4; n++) run_txn(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
        drain();

        // Timeout, then a late response that must only set stray_resp.
        set_req(0, 1'b0, 8'h20);
        run_txn(TO, 1'b0, 1'b0, 1'b0);
        tick();
        sys_resp_valid = 1'b1;
        sys_resp_data  = 8'h77;
        tick();
        sys_resp_valid = 1'b0;
        exp_stray = 1'b1;
        check_quiet("late");
        tick();
        check_quiet("late2");

        // Response in the same cycle the timeout would fire.
        set_req(1, 1'b0, 8'h21);
        run_txn(TO - 1, 1'b0, 1'b0, 1'b0);

        // Reset while waiting; requester 1 completed last before the abandoned read.
        do_reset();
        set_req(1, 1'b1, 8'h33);
        run_txn(0, 1'b0, 1'b0, 1'b0);
        set_req(2, 1'b0, 8'h44);
        tick();
        check_eq("rst_issue", 32'(sys_req_valid), 32'(1));
        tick();
        tick();
        check_eq("rst_wait_busy", 32'(busy), 32'(1));
        #2;
        rstn_sys  = 1'b0;
        req_valid = '0;
        #1;
        check_all_zero("midrst");
        tick();
        rstn_sys = 1'b1;
        model_reset();
        tick();
        check_quiet("postrst");
        sys_resp_valid = 1'b1;
        sys_resp_data  = 8'h5A;
        tick();
        sys_resp_valid = 1'b0;
        exp_stray = 1'b1;
        check_quiet("postrst_stray");
        set_req(1, 1'b0, 8'h51);
        set_req(2, 1'b0, 8'h52);
        run_txn(1, 1'b0, 1'b0, 1'b0);
        drain();

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int d;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, ($urandom_range(0, 2) == 0), 8'($urandom));
            end
            if (pick() < 0) set_req(int'($urandom_range(0, N - 1)), 1'b0, 8'($urandom));
            case ($urandom_range(0, 3))
                0:       d = TO - 1;
                1:       d = TO + int'($urandom_range(0, 2));
                default: d = int'($urandom_range(0, TO - 1));
            endcase
            run_txn(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
